// File: rtl/alu_8.sv
// alu_8: 8-bit execute-stage ALU with registered result and flags.
// Ripple add/sub, logic and shift units feed a flag mux and output flops.

module alu_8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // one-bit full adder cell
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

module alu_8_addsub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] r,
  output logic       cf,
  output logic       vf
);

  logic [7:0] bx;
  logic [8:0] c;

  // subtract is a + ~b + 1
  always_comb begin
    bx = b ^ {8{sub}};
  end

  assign c[0] = sub;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_fa
      alu_8_fa u_fa (
        .a  (a[i]),
        .b  (bx[i]),
        .ci (c[i]),
        .s  (r[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // carry-out inverts into borrow on subtract;
  // signed overflow when the top two carries disagree
  always_comb begin
    cf = c[8] ^ sub;
    vf = c[8] ^ c[7];
  end

endmodule

module alu_8_logic (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] sel,
  output logic [7:0] r
);

  // sel is opcode[1:0]: 10 and, 11 or, 00 xor, 01 not
  always_comb begin
    r = '0;
    unique case (sel)
      2'b10: r = a & b;
      2'b11: r = a | b;
      2'b00: r = a ^ b;
      2'b01: r = ~a;
      default: r = '0;
    endcase
  end

endmodule

module alu_8_shift (
  input  logic [7:0] a,
  input  logic       right,
  output logic [7:0] r,
  output logic       co
);

  // single-bit logical shift; the bit shifted out goes to carry
  always_comb begin
    if (right) begin
      r  = {1'b0, a[7:1]};
      co = a[0];
    end else begin
      r  = {a[6:0], 1'b0};
      co = a[7];
    end
  end

endmodule

module alu_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] opcode,
  output logic [7:0] out,
  output logic       carry,
  output logic       zero,
  output logic       neg,
  output logic       ovf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [7:0] as_r;
  logic       as_c;
  logic       as_v;
  logic [7:0] lg_r;
  logic [7:0] sh_r;
  logic       sh_c;

  logic [7:0] out_d,   out_q;
  logic       carry_d, carry_q;
  logic       zero_d,  zero_q;
  logic       neg_d,   neg_q;
  logic       ovf_d,   ovf_q;

  alu_8_addsub u_addsub (
    .a   (a),
    .b   (b),
    .sub (opcode[0]),
    .r   (as_r),
    .cf  (as_c),
    .vf  (as_v)
  );

  alu_8_logic u_logic (
    .a   (a),
    .b   (b),
    .sel (opcode[1:0]),
    .r   (lg_r)
  );

  alu_8_shift u_shift (
    .a     (a),
    .right (opcode[0]),
    .r     (sh_r),
    .co    (sh_c)
  );

  // pick the unit result and its flags, then derive zero/neg
  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (opcode)
      OP_ADD, OP_SUB: begin
        out_d   = as_r;
        carry_d = as_c;
        ovf_d   = as_v;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        out_d = lg_r;
      end
      OP_SHL, OP_SHR: begin
        out_d   = sh_r;
        carry_d = sh_c;
      end
      default: begin
        out_d = '0;
      end
    endcase
    zero_d = (out_d == 8'h00);
    neg_d  = out_d[7];
  end

  // single pipeline register; reset clears result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_alu_8.sv
// tb_alu_8: directed literal vectors plus randomized stimulus
// checked against an arithmetic reference model of alu_8.

module tb_alu_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic [7:0] out;
  logic       carry;
  logic       zero;
  logic       neg;
  logic       ovf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_8 dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .out    (out),
    .carry  (carry),
    .zero   (zero),
    .neg    (neg),
    .ovf    (ovf)
  );

  function automatic logic [11:0] model(
    input logic       r,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [2:0] op
  );
    int ua;
    int ub;
    int sa;
    int sb;
    int t;
    logic [7:0] res;
    logic c;
    logic v;
    ua  = int'(x);
    ub  = int'(y);
    sa  = (ua > 127) ? ua - 256 : ua;
    sb  = (ub > 127) ? ub - 256 : ub;
    res = 8'h00;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      3'd0: begin
        t   = ua + ub;
        res = 8'(t % 256);
        c   = (t > 255);
        t   = sa + sb;
        v   = (t > 127) || (t < -128);
      end
      3'd1: begin
        t   = ua - ub;
        res = 8'((t + 256) % 256);
        c   = (ua < ub);
        t   = sa - sb;
        v   = (t > 127) || (t < -128);
      end
      3'd2: res = x & y;
      3'd3: res = x | y;
      3'd4: res = x ^ y;
      3'd5: res = ~x;
      3'd6: begin
        res = 8'((ua * 2) % 256);
        c   = (ua >= 128);
      end
      default: begin
        res = 8'(ua / 2);
        c   = (ua % 2 == 1);
      end
    endcase
    if (r) return 12'h000;
    return {res, c, (res == 8'h00), (ua >= 0) && (res >= 8'h80), v};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {out, carry, zero, neg, ovf};
  endfunction

  task automatic chk(input string nm, input logic [11:0] got,
                     input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got out=%02h c=%b z=%b n=%b v=%b, expected out=%02h c=%b z=%b n=%b v=%b",
               nm, got[11:4], got[3], got[2], got[1], got[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // drive one operation, let one edge capture it, check the model
  task automatic apply(input logic r, input logic [7:0] x,
                       input logic [7:0] y, input logic [2:0] op,
                       output logic [11:0] exp);
    rst    = r;
    a      = x;
    b      = y;
    opcode = op;
    exp    = model(r, x, y, op);
    @(posedge clk);
    #1;
    chk($sformatf("model r=%b op=%0d a=%02h b=%02h", r, op, x, y),
        dut_vec(), exp);
  endtask

  // same as apply, plus a hand-computed literal result {out,c,z,n,v}
  task automatic lit(input logic r, input logic [7:0] x,
                     input logic [7:0] y, input logic [2:0] op,
                     input logic [7:0] ro, input logic [3:0] f);
    logic [11:0] e;
    apply(r, x, y, op, e);
    chk($sformatf("literal r=%b op=%0d a=%02h b=%02h", r, op, x, y),
        dut_vec(), {ro, f});
  endtask

  logic [7:0] sw_out [3][8];
  logic [3:0] sw_flg [3][8];
  logic [7:0] sw_a   [3];
  logic [7:0] sw_b   [3];

  initial begin
    logic [11:0] e;
    logic [11:0] snap;

    sw_a[0] = 8'h00; sw_b[0] = 8'h00;
    sw_a[1] = 8'hFF; sw_b[1] = 8'hFF;
    sw_a[2] = 8'hAA; sw_b[2] = 8'h55;

    // flags are {c,z,n,v}
    sw_out[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    sw_flg[0] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                  4'b0100, 4'b0010, 4'b0100, 4'b0100};
    sw_out[1] = '{8'hFE, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFE, 8'h7F};
    sw_flg[1] = '{4'b1010, 4'b0100, 4'b0010, 4'b0010,
                  4'b0100, 4'b0100, 4'b1010, 4'b1000};
    sw_out[2] = '{8'hFF, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'h54, 8'h55};
    sw_flg[2] = '{4'b0010, 4'b0001, 4'b0100, 4'b0010,
                  4'b0010, 4'b0000, 4'b1000, 4'b0000};

    // reset held two cycles, then first result after release
    lit(1'b1, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0000);
    lit(1'b1, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0000);
    lit(1'b0, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1100);

    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 8; k++)
        lit(1'b0, sw_a[s], sw_b[s], 3'(k), sw_out[s][k], sw_flg[s][k]);

    lit(1'b0, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0011);
    lit(1'b0, 8'h80, 8'h01, 3'd1, 8'h7F, 4'b0001);
    lit(1'b0, 8'h01, 8'h02, 3'd1, 8'hFF, 4'b1010);

    // mid-stream reset discards the pending op
    lit(1'b0, 8'h80, 8'h80, 3'd0, 8'h00, 4'b1101);
    lit(1'b1, 8'h80, 8'h80, 3'd0, 8'h00, 4'b0000);
    lit(1'b0, 8'h40, 8'h40, 3'd0, 8'h80, 4'b0011);

    // latency run: opcode follows cycle index, inputs wiggle mid-cycle
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 8'($urandom), 8'($urandom), 3'(k), e);
      snap = dut_vec();
      #2;
      a      = 8'($urandom);
      b      = 8'($urandom);
      opcode = 3'($urandom);
      @(negedge clk);
      chk("stable mid-cycle", dut_vec(), snap);
    end

    // longer random run with occasional reset
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom),
            3'($urandom), e);
      if (k % 4 == 0) begin
        snap = dut_vec();
        #2;
        a = ~a;
        b = b + 8'd1;
        opcode = opcode + 3'd3;
        @(negedge clk);
        chk("stable random", dut_vec(), snap);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
